// File: rtl/ux607_icache_ram_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ux607_icache_pkg
// Brief    : Shared power-mode encodings, FSM states and wake defaults for the
//            banked UX607 I-cache RAM array.
// Revision : 1.0 - initial release
// ============================================================================
package ux607_icache_pkg;

  localparam logic [1:0] PWR_ACT = 2'd0;
  localparam logic [1:0] PWR_LS  = 2'd1;
  localparam logic [1:0] PWR_DS  = 2'd2;
  localparam logic [1:0] PWR_SD  = 2'd3;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_LOWPWR = 2'd1,
    ST_WAKE   = 2'd2
  } pwr_state_e;

  localparam int WAKE_LS_DEF = 1;
  localparam int WAKE_DS_DEF = 4;
  localparam int WAKE_SD_DEF = 16;

  // Largest of the three wake latencies; sizes the wake counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ux607_icache_ram_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : ux607_icache_ram_bank_if
// Brief    : Request/response and power-request bundle between the I-cache
//            controller (master) and the banked RAM array (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface ux607_icache_ram_bank_if #(
  parameter int AW = 7,
  parameter int DW = 64,
  parameter int MW = 8,
  parameter int NB = 4
);
  logic [1:0]       pwr_req;
  logic             pwr_ack;
  logic             req_valid;
  logic             req_ready;
  logic [NB-1:0]    req_bank_en;
  logic             req_we;
  logic [AW-1:0]    req_addr;
  logic [MW-1:0]    req_wem;
  logic [DW-1:0]    req_din;
  logic             rsp_valid;
  logic [NB*DW-1:0] rsp_dout;

  modport master (
    output pwr_req, req_valid, req_bank_en, req_we, req_addr, req_wem, req_din,
    input  pwr_ack, req_ready, rsp_valid, rsp_dout
  );

  modport slave (
    input  pwr_req, req_valid, req_bank_en, req_we, req_addr, req_wem, req_din,
    output pwr_ack, req_ready, rsp_valid, rsp_dout
  );
endinterface
`default_nettype wire

// File: rtl/ux607_gnrl_ram.sv
`default_nettype none
// ============================================================================
// Module   : ux607_gnrl_ram
// Brief    : Single-port synchronous RAM macro model with byte write mask and
//            light-sleep / deep-sleep / shutdown pins. Read data is registered
//            and held until the next read.
// Revision : 1.0 - initial release
// ============================================================================
module ux607_gnrl_ram #(
  parameter int DP           = 128,
  parameter int DW           = 64,
  parameter int MW           = 8,
  parameter int AW           = 7,
  parameter int FORCE_X2ZERO = 0
) (
  input  logic          clk,
  input  logic          ls,
  input  logic          ds,
  input  logic          sd,
  input  logic          cs,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [MW-1:0] wem,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);
  localparam int LW = DW / MW;

  logic [DW-1:0] r_mem [DP];
  logic [DW-1:0] r_dout;
  logic          w_lowpwr;

  assign w_lowpwr = ls | ds | sd;
  assign dout     = r_dout;

  // Array access; no access while any low-power pin is high. In shutdown the
  // read register is optionally forced to zero so no stale data leaks out.
  always_ff @(posedge clk) begin
    if (cs && !w_lowpwr) begin
      if (we) begin
        for (int i = 0; i < MW; i++) begin
          if (wem[i]) r_mem[addr][i*LW +: LW] <= din[i*LW +: LW];
        end
      end else begin
        r_dout <= r_mem[addr];
      end
    end else if (sd && (FORCE_X2ZERO != 0)) begin
      r_dout <= '0;
    end
  end
endmodule
`default_nettype wire

// File: rtl/ux607_icache_ram_bank_pwrctl.sv
`default_nettype none
// ============================================================================
// Module   : ux607_icache_ram_pwrctl
// Brief    : Power-state sequencer: ACTIVE/LOWPWR/WAKE FSM, wake counter,
//            registered ls/ds/sd pins, request gating and pwr_ack.
// Revision : 1.0 - initial release
// ============================================================================
module ux607_icache_ram_pwrctl
  import ux607_icache_pkg::*;
#(
  parameter int WAKE_LS = WAKE_LS_DEF,
  parameter int WAKE_DS = WAKE_DS_DEF,
  parameter int WAKE_SD = WAKE_SD_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] pwr_req,
  input  logic       rd_busy,
  output logic       ready,
  output logic       pwr_ack,
  output logic       ls,
  output logic       ds,
  output logic       sd
);
  localparam int CW = $clog2(max3(WAKE_LS, WAKE_DS, WAKE_SD)) + 1;
  localparam logic [CW-1:0] LOAD_LS = CW'(WAKE_LS - 1);
  localparam logic [CW-1:0] LOAD_DS = CW'(WAKE_DS - 1);
  localparam logic [CW-1:0] LOAD_SD = CW'(WAKE_SD - 1);

  pwr_state_e    r_state;
  logic [1:0]    r_mode;
  logic [CW-1:0] r_cnt;
  logic          r_ls, r_ds, r_sd;

  assign ls      = r_ls;
  assign ds      = r_ds;
  assign sd      = r_sd;
  assign ready   = (r_state == ST_ACTIVE) && (pwr_req == PWR_ACT);
  assign pwr_ack = ((r_state == ST_ACTIVE) && (pwr_req == PWR_ACT)) ||
                   ((r_state == ST_LOWPWR) && (r_mode == pwr_req));

  // Sequencer: enter a mode only once reads have drained; any change of the
  // request while sleeping goes through WAKE and ACTIVE first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ACTIVE;
      r_mode  <= PWR_ACT;
      r_cnt   <= '0;
      r_ls    <= 1'b0;
      r_ds    <= 1'b0;
      r_sd    <= 1'b0;
    end else begin
      case (r_state)
        ST_ACTIVE: begin
          if ((pwr_req != PWR_ACT) && !rd_busy) begin
            r_state <= ST_LOWPWR;
            r_mode  <= pwr_req;
            r_ls    <= (pwr_req == PWR_LS);
            r_ds    <= (pwr_req == PWR_DS);
            r_sd    <= (pwr_req == PWR_SD);
          end
        end
        ST_LOWPWR: begin
          if (pwr_req != r_mode) begin
            r_state <= ST_WAKE;
            r_ls    <= 1'b0;
            r_ds    <= 1'b0;
            r_sd    <= 1'b0;
            case (r_mode)
              PWR_LS:  r_cnt <= LOAD_LS;
              PWR_DS:  r_cnt <= LOAD_DS;
              default: r_cnt <= LOAD_SD;
            endcase
          end
        end
        ST_WAKE: begin
          if (r_cnt == '0) begin
            r_state <= ST_ACTIVE;
            r_mode  <= PWR_ACT;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= ST_ACTIVE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/ux607_icache_ram_bank.sv
`default_nettype none
// ============================================================================
// Module   : ux607_icache_ram_bank
// Brief    : NB-way banked I-cache RAM array with request/response handshake,
//            optional output register and power-state sequencing.
// Revision : 1.0 - initial release
// ============================================================================
module ux607_icache_ram_bank
  import ux607_icache_pkg::*;
#(
  parameter int AW      = 7,
  parameter int DP      = 128,
  parameter int DW      = 64,
  parameter int MW      = 8,
  parameter int NB      = 4,
  parameter int OREG    = 1,
  parameter int WAKE_LS = WAKE_LS_DEF,
  parameter int WAKE_DS = WAKE_DS_DEF,
  parameter int WAKE_SD = WAKE_SD_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ux607_icache_ram_bank_if.slave bus
);
  logic             w_ready;
  logic             w_accept;
  logic             w_rd_accept;
  logic [MW-1:0]    w_wem;
  logic             w_ls, w_ds, w_sd;
  logic [NB*DW-1:0] w_ram_dout;
  logic             r_rd_s1;

  assign w_accept      = bus.req_valid & w_ready;
  assign w_rd_accept   = w_accept & ~bus.req_we;
  assign w_wem         = bus.req_we ? bus.req_wem : '0;
  assign bus.req_ready = w_ready;

  // A read is in flight while the RAM still owes data (the cycle after accept).
  ux607_icache_ram_pwrctl #(
    .WAKE_LS (WAKE_LS),
    .WAKE_DS (WAKE_DS),
    .WAKE_SD (WAKE_SD)
  ) u_pwrctl (
    .clk     (clk),
    .rst_n   (rst_n),
    .pwr_req (bus.pwr_req),
    .rd_busy (r_rd_s1),
    .ready   (w_ready),
    .pwr_ack (bus.pwr_ack),
    .ls      (w_ls),
    .ds      (w_ds),
    .sd      (w_sd)
  );

  generate
    for (genvar b = 0; b < NB; b++) begin : g_bank
      ux607_gnrl_ram #(
        .DP           (DP),
        .DW           (DW),
        .MW           (MW),
        .AW           (AW),
        .FORCE_X2ZERO (0)
      ) u_ram (
        .clk  (clk),
        .ls   (w_ls),
        .ds   (w_ds),
        .sd   (w_sd),
        .cs   (w_accept & bus.req_bank_en[b]),
        .we   (bus.req_we),
        .addr (bus.req_addr),
        .wem  (w_wem),
        .din  (bus.req_din),
        .dout (w_ram_dout[b*DW +: DW])
      );
    end
  endgenerate

  // First read-pipeline stage: RAM data is valid while this is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_s1 <= 1'b0;
    else        r_rd_s1 <= w_rd_accept;
  end

  generate
    if (OREG != 0) begin : g_oreg
      logic             r_rd_s2;
      logic [NB*DW-1:0] r_dout;

      // Output register: captures RAM data once per read; disabled banks
      // present their held RAM output so their slices do not change.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rd_s2 <= 1'b0;
          r_dout  <= '0;
        end else begin
          r_rd_s2 <= r_rd_s1;
          if (r_rd_s1) r_dout <= w_ram_dout;
        end
      end

      assign bus.rsp_valid = r_rd_s2;
      assign bus.rsp_dout  = r_dout;
    end else begin : g_direct
      assign bus.rsp_valid = r_rd_s1;
      assign bus.rsp_dout  = w_ram_dout;
    end
  endgenerate
endmodule
`default_nettype wire

// File: tb/tb_ux607_icache_ram_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_ux607_icache_ram_bank
// Brief    : Directed self-checking bench with a response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ux607_icache_ram_bank;
  import ux607_icache_pkg::*;

  localparam int AW = 7, DP = 128, DW = 64, MW = 8, NB = 4, OREG = 1;
  localparam int WLS = 1, WDS = 4, WSD = 16;
  localparam int OW = NB * DW;

  typedef struct packed {
    logic [OW-1:0] data;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ux607_icache_ram_bank_if #(.AW(AW), .DW(DW), .MW(MW), .NB(NB)) bus ();

  ux607_icache_ram_bank #(
    .AW(AW), .DP(DP), .DW(DW), .MW(MW), .NB(NB), .OREG(OREG),
    .WAKE_LS(WLS), .WAKE_DS(WDS), .WAKE_SD(WSD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t          sb[$];
  logic [DW-1:0] mdl_mem [NB][DP];
  logic [DW-1:0] mdl_last [NB];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;

  task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; sample after the edge and retire responses against the scoreboard.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (sb.size() > 0 && sb[0].due < cyc) begin
      chk("rsp_missing", {{(OW-1){1'b0}}, bus.rsp_valid}, 1);
      void'(sb.pop_front());
    end
    if (bus.rsp_valid) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", {{(OW-1){1'b0}}, bus.rsp_valid}, 0);
      end else begin
        e = sb.pop_front();
        chk("rsp_data", bus.rsp_dout, e.data);
        chk("rsp_latency", cyc, e.due);
      end
    end
  endtask

  task automatic access(input logic we, input logic [NB-1:0] en, input logic [AW-1:0] a,
                        input logic [MW-1:0] m, input logic [DW-1:0] d);
    exp_t e;
    bus.req_valid   = 1'b1;
    bus.req_we      = we;
    bus.req_bank_en = en;
    bus.req_addr    = a;
    bus.req_wem     = m;
    bus.req_din     = d;
    if (we) begin
      for (int b = 0; b < NB; b++)
        for (int i = 0; i < MW; i++)
          if (en[b] && m[i]) mdl_mem[b][a][i*8 +: 8] = d[i*8 +: 8];
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (en[b]) mdl_last[b] = mdl_mem[b][a];
        e.data[b*DW +: DW] = mdl_last[b];
      end
      e.due = cyc + 1 + OREG;
      sb.push_back(e);
    end
    step();
  endtask

  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  // Release the power request and count the cycles the array stays not-ready.
  task automatic wake_count(input string tag, input int exp_n);
    int   n;
    logic ack_seen;
    logic pin_seen;
    n = 0; ack_seen = 1'b0; pin_seen = 1'b0;
    bus.pwr_req = PWR_ACT;
    for (int k = 0; k < 100; k++) begin
      step();
      if (bus.req_ready) break;
      n++;
      ack_seen |= bus.pwr_ack;
      pin_seen |= dut.w_ls | dut.w_ds | dut.w_sd;
    end
    chk({tag, "_len"}, n, exp_n);
    chk({tag, "_ack_low"}, {{(OW-1){1'b0}}, ack_seen}, 0);
    chk({tag, "_pins_low"}, {{(OW-1){1'b0}}, pin_seen}, 0);
  endtask

  initial begin
    int            n;
    logic          both;
    logic [OW-1:0] v;

    bus.pwr_req = PWR_ACT; bus.req_valid = 1'b0; bus.req_we = 1'b0;
    bus.req_bank_en = '0; bus.req_addr = '0; bus.req_wem = '0; bus.req_din = '0;
    #12;
    chk("rst_rsp_valid", {{(OW-1){1'b0}}, bus.rsp_valid}, 0);
    chk("rst_rsp_dout", bus.rsp_dout, 0);
    chk("rst_pwr_ack", {{(OW-1){1'b0}}, bus.pwr_ack}, 1);
    chk("rst_pins", {{(OW-3){1'b0}}, dut.w_ls, dut.w_ds, dut.w_sd}, 0);
    rst_n = 1'b1;
    idle(2);
    chk("rst_ready", {{(OW-1){1'b0}}, bus.req_ready}, 1);

    // Per-bank writes, then a full-width read.
    for (int b = 0; b < NB; b++)
      access(1'b1, 4'(1 << b), 7'd5, 8'hFF, 64'hA5A5_0000_0000_0001 + 64'(b));
    access(1'b0, 4'hF, 7'd5, 8'h00, 64'd0);
    idle(3);

    // Byte mask.
    access(1'b1, 4'hF, 7'd3, 8'hFF, {DW{1'b1}});
    access(1'b1, 4'hF, 7'd3, 8'h0F, 64'd0);
    access(1'b0, 4'hF, 7'd3, 8'h00, 64'd0);
    idle(3);

    // Partial enable: banks 1 and 3 hold the previous slice.
    access(1'b0, 4'b0101, 7'd5, 8'h00, 64'd0);
    idle(3);

    // Back-to-back mix, write-then-read same address.
    access(1'b1, 4'hF, 7'd9, 8'hFF, 64'h0123_4567_89AB_CDEF);
    access(1'b0, 4'hF, 7'd9, 8'h00, 64'd0);
    access(1'b0, 4'b1010, 7'd5, 8'h00, 64'd0);
    access(1'b1, 4'h3, 7'd9, 8'hF0, 64'hFFFF_0000_FFFF_0000);
    access(1'b0, 4'hF, 7'd9, 8'h00, 64'd0);
    idle(4);
    chk("drain1", sb.size(), 0);

    // Light sleep entry/exit.
    bus.pwr_req = PWR_LS;
    #1;
    chk("ls_ready_drop", {{(OW-1){1'b0}}, bus.req_ready}, 0);
    step();
    chk("ls_pin", {{(OW-3){1'b0}}, dut.w_ls, dut.w_ds, dut.w_sd}, 3'b100);
    chk("ls_ack", {{(OW-1){1'b0}}, bus.pwr_ack}, 1);
    step();
    wake_count("ls_wake", WLS);
    access(1'b0, 4'hF, 7'd5, 8'h00, 64'd0);
    idle(3);

    // Shutdown requested with a read in flight.
    access(1'b0, 4'hF, 7'd9, 8'h00, 64'd0);
    bus.req_valid = 1'b0;
    bus.pwr_req   = PWR_SD;
    #1;
    chk("sd_ready_drop", {{(OW-1){1'b0}}, bus.req_ready}, 0);
    step();
    chk("sd_not_yet", {{(OW-1){1'b0}}, dut.w_sd}, 0);
    step();
    chk("sd_pin", {{(OW-3){1'b0}}, dut.w_ls, dut.w_ds, dut.w_sd}, 3'b001);
    chk("sd_ack", {{(OW-1){1'b0}}, bus.pwr_ack}, 1);
    chk("sd_drain", sb.size(), 0);
    wake_count("sd_wake", WSD);

    // Deep sleep, then change to shutdown without waking fully first.
    bus.pwr_req = PWR_DS;
    step();
    chk("ds_pin", {{(OW-3){1'b0}}, dut.w_ls, dut.w_ds, dut.w_sd}, 3'b010);
    bus.pwr_req = PWR_SD;
    n = 0; both = 1'b0;
    for (int k = 0; k < 100; k++) begin
      step();
      both |= dut.w_ds & dut.w_sd;
      if (dut.w_sd) break;
      n++;
    end
    chk("ds2sd_gap", n, WDS + 1);
    chk("ds2sd_overlap", {{(OW-1){1'b0}}, both}, 0);
    chk("ds2sd_ack", {{(OW-1){1'b0}}, bus.pwr_ack}, 1);

    // Reset during wake at counter value 7.
    bus.pwr_req = PWR_ACT;
    for (int k = 0; k < 100; k++) begin
      step();
      if (!bus.req_ready && dut.u_pwrctl.r_cnt == 5'd7) break;
    end
    chk("wake_cnt7", {{(OW-5){1'b0}}, dut.u_pwrctl.r_cnt}, 7);
    rst_n = 1'b0;
    #1;
    chk("wrst_pins", {{(OW-3){1'b0}}, dut.w_ls, dut.w_ds, dut.w_sd}, 0);
    chk("wrst_ready", {{(OW-1){1'b0}}, bus.req_ready}, 1);
    chk("wrst_ack", {{(OW-1){1'b0}}, bus.pwr_ack}, 1);
    chk("wrst_rsp_valid", {{(OW-1){1'b0}}, bus.rsp_valid}, 0);
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Reset with a read in flight: the response is dropped.
    access(1'b1, 4'hF, 7'd20, 8'hFF, 64'hDEAD_BEEF_0000_1234);
    access(1'b0, 4'hF, 7'd20, 8'h00, 64'd0);
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_rsp_valid", {{(OW-1){1'b0}}, bus.rsp_valid}, 0);
    chk("arst_rsp_dout", bus.rsp_dout, 0);
    sb.delete();
    idle(2);
    rst_n = 1'b1;
    idle(3);

    // Normal operation after reset.
    access(1'b1, 4'hF, 7'd21, 8'hFF, 64'h5555_AAAA_1234_5678);
    access(1'b0, 4'hF, 7'd21, 8'h00, 64'd0);
    idle(4);
    chk("drain_final", sb.size(), 0);
    v = bus.rsp_dout;
    chk("final_slice0", {{(OW-DW){1'b0}}, v[DW-1:0]}, 64'h5555_AAAA_1234_5678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/ux607_icache_ram_bank.md
# ux607_icache_ram_bank

Banked, power-managed instruction-cache data/tag RAM array for the UX607 I-cache. It replaces the single-instance cache RAM with NB independently enabled banks (one per way), adds a request/response handshake with an optional output register stage, and adds a power-state sequencer that drives the per-bank light-sleep/deep-sleep/shutdown pins with programmable wake-up latencies. It sits between the I-cache controller and the `ux607_gnrl_ram` macros.

## Interface
- AW, 7: index width (DP = 2**AW).
- DP, 128: entries per bank.
- DW, 64: data width per bank.
- MW, 8: write-mask width per bank (byte lanes, DW/8).
- NB, 4: bank/way count, 1..8.
- OREG, 1: 1 = registered output (2-cycle read), 0 = direct RAM output (1-cycle read).
- WAKE_LS, 1 / WAKE_DS, 4 / WAKE_SD, 16: wake cycles from each low-power mode, each at least 1.
- clk  in  1  clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- pwr_req  in  2  requested mode: 0 ACTIVE, 1 LS, 2 DS, 3 SD.
- pwr_ack  out  1  array is settled in pwr_req mode.
- req_valid  in  1  access request.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_bank_en  in  NB  banks taking part in the access.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  AW  index.
- req_wem  in  MW  byte-write mask, applied to every enabled bank.
- req_din  in  DW  write data, common to all enabled banks.
- rsp_valid  out  1  read data valid.
- rsp_dout  out  NB*DW  bank b at [b*DW +: DW].

## Operation
- FSM states ACTIVE, LOWPWR, WAKE. Reset state is ACTIVE.
- req_ready = (state==ACTIVE) & (pwr_req==0).
- On acceptance, bank b gets cs = req_bank_en[b]. All banks share wem = req_we ? req_wem : 0, plus addr and din.
- Writes produce no response.
- Reads produce exactly one rsp_valid pulse.
- Non-enabled banks hold their previous rsp_dout slice (cs low, no read).
- ACTIVE to LOWPWR: taken when pwr_req!=0 and no read is in flight (output stage empty).
  - Records the mode.
  - Asserts exactly one of ls/ds/sd to all banks from the next cycle.
- In LOWPWR, pwr_req==0 moves the FSM to WAKE.
  - The pin deasserts on entry to WAKE.
  - The wake counter loads WAKE_x-1 for the recorded mode.
- WAKE decrements the counter each cycle. At 0 the FSM moves to ACTIVE.
- In LOWPWR, a pwr_req change to a different non-zero mode also goes to WAKE. The FSM returns to ACTIVE, then re-enters the new mode. No direct mode-to-mode switch is allowed.
- pwr_ack = 1 in two cases:
  - state==ACTIVE and pwr_req==0
  - state==LOWPWR and recorded mode==pwr_req
- pwr_ack = 0 otherwise, including during WAKE.
- After SD, RAM contents are undefined; the cache controller must invalidate. LS and DS retain contents.
- Wake counter width is $clog2(max WAKE)+1. There is no wrap: the counter stops at 0.

## Timing
- Reset values:
  - state ACTIVE
  - ls/ds/sd 0
  - wake counter 0
  - rsp_valid 0
  - rsp_dout 0 (OREG=1 only; with OREG=0 the RAM output is undefined until the first read)
  - pwr_ack 1 when pwr_req==0
- Read latency: accept at cycle N, rsp_valid at N+1 (OREG=0) or N+2 (OREG=1).
- Throughput is one access per cycle, back-to-back, with reads and writes mixed freely.
- Write-then-read to the same address on consecutive cycles returns the new data.
- pwr_req rising while a read is in flight: req_ready drops in the same cycle. The pending rsp_valid still issues, then LOWPWR is entered the following cycle.
- Minimum LOWPWR residency is 1 cycle.
- Total wake latency is WAKE_x cycles from the first pwr_req==0 cycle in LOWPWR to req_ready=1.
- Asynchronous reset mid-access or mid-wake:
  - All outputs return to reset values immediately.
  - A pending response is dropped.
  - Pins deassert.

## Structure
- Shared package `ux607_icache_pkg`:
  - pwr mode encodings (PWR_ACT/LS/DS/SD)
  - FSM state encoding
  - default wake constants
- One sub-module, `ux607_icache_ram_pwrctl`, holds the FSM, wake counter, pin outputs and pwr_ack.
- The top level instantiates NB `ux607_gnrl_ram` (DP, DW, MW, AW, FORCE_X2ZERO=0) via a generate loop, plus the optional output register and rsp_valid pipeline.

## Test plan
- Per-bank write/read: write 64'hA5A5_0000_0000_0001+b to addr 5 of each bank individually, then read with req_bank_en=4'hF. Each rsp_dout slice matches; rsp_valid appears 2 cycles after accept (OREG=1).
- Byte mask: write all-ones to addr 3, then write 0 with req_wem=8'h0F. Read returns 64'hFFFF_FFFF_0000_0000.
- LS entry/exit: pwr_req=1 while idle puts ls high the next cycle with pwr_ack=1. pwr_req=0 deasserts ls; req_ready returns after exactly WAKE_LS cycles; earlier data is intact.
- SD with a read in flight: accept a read, then set pwr_req=3 the same cycle after. rsp_valid still fires once, then sd asserts. Wake takes 16 cycles with pwr_ack=0 throughout.
- Mode change in LOWPWR: DS to SD passes through WAKE (4 cycles) and ACTIVE before sd asserts; ds and sd are never high together.
- Reset during WAKE: drop rst_n at wake count 7. State goes to ACTIVE, all pins are 0, and rsp_valid is 0 asynchronously.
